// File: rtl/dma_mem.sv
// dma_mem: block-transfer master for the 64x8 data memory.
// Performs memory-to-memory block copy (modo=0) or constant block fill (modo=1).
// Optional feature macro: DMA_OVERLAP_EN (copies whose destination overlaps the
// source from above run in descending order, giving memmove semantics).
module dma_mem #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              modo,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W:0]   len,
  input  logic [DATA_W-1:0] fill_val,
  input  logic [DATA_W-1:0] mem_rd,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(2**ADDR_W);
  localparam logic [ADDR_W:0] IDX_ONE = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    LEER,
    ESCRIBIR,
    FIN
  } state_t;

  state_t              state_q, state_d;
  logic                modo_q, modo_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [DATA_W-1:0]   fill_q, fill_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     idx_q, idx_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                desc_q, desc_d;

  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wd_q, mem_wd_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [ADDR_W:0]     len_eff;
  logic                last;
`ifdef DMA_OVERLAP_EN
  logic [ADDR_W-1:0]   dist;
`endif

  // Next-state logic; bus outputs are derived from the next state so they register cleanly
  always_comb begin
    state_d    = state_q;
    modo_d     = modo_q;
    src_d      = src_q;
    dst_d      = dst_q;
    fill_d     = fill_q;
    len_d      = len_q;
    idx_d      = idx_q;
    data_d     = data_q;
    desc_d     = desc_q;
    len_eff    = (len > MAX_LEN) ? MAX_LEN : len;
    last       = desc_q ? (idx_q == '0) : ((idx_q + IDX_ONE) == len_q);
`ifdef DMA_OVERLAP_EN
    dist       = dst - src;
`endif

    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (start) begin
          modo_d = modo;
          src_d  = src;
          dst_d  = dst;
          fill_d = fill_val;
          len_d  = len_eff;
          desc_d = 1'b0;
`ifdef DMA_OVERLAP_EN
          if (!modo && (dist != '0) && ({1'b0, dist} < len_eff)) begin
            desc_d = 1'b1;
          end
`endif
          if (len_eff == '0) begin
            state_d = FIN;
          end else begin
            idx_d   = desc_d ? (len_eff - IDX_ONE) : '0;
            state_d = modo ? ESCRIBIR : LEER;
          end
        end
      end
      LEER: begin
        data_d  = mem_rd;
        state_d = ESCRIBIR;
      end
      ESCRIBIR: begin
        idx_d = desc_q ? (idx_q - IDX_ONE) : (idx_q + IDX_ONE);
        if (last) begin
          state_d = FIN;
        end else begin
          state_d = modo_q ? ESCRIBIR : LEER;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d     = (state_d != IDLE);
    done_d     = (state_d == FIN);
    mem_we_d   = (state_d == ESCRIBIR);
    mem_addr_d = '0;
    mem_wd_d   = '0;
    if (state_d == LEER) begin
      mem_addr_d = src_d + idx_d[ADDR_W-1:0];
    end else if (state_d == ESCRIBIR) begin
      mem_addr_d = dst_d + idx_d[ADDR_W-1:0];
      mem_wd_d   = modo_d ? fill_d : data_d;
    end
  end

  // Transfer FSM and registered memory-bus outputs; reset drops the bus immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      modo_q     <= 1'b0;
      src_q      <= '0;
      dst_q      <= '0;
      fill_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      desc_q     <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_wd_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      modo_q     <= modo_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      fill_q     <= fill_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      desc_q     <= desc_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wd_q   <= mem_wd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_wd   = mem_wd_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_dma_mem.sv
// tb_dma_mem: directed bench for dma_mem with a 64x8 memory and a transfer-level model.
module tb_dma_mem;

  logic       clk;
  logic       reset;
  logic       start;
  logic       modo;
  logic [5:0] src;
  logic [5:0] dst;
  logic [6:0] len;
  logic [7:0] fill_val;
  logic [7:0] mem_rd;
  logic       mem_we;
  logic [5:0] mem_addr;
  logic [7:0] mem_wd;
  logic       busy;
  logic       done;

  logic       tb_we;
  logic [5:0] tb_addr;
  logic [7:0] tb_wd;
  logic [7:0] mem     [64];
  logic [7:0] ref_mem [64];

  typedef struct {
    logic       busy;
    logic       done;
    logic       we;
    logic       chk_addr;
    logic [5:0] addr;
    logic       chk_wd;
    logic [7:0] wd;
  } exp_t;

  exp_t       exp_q[$];
  int         pend_addr[$];
  logic [7:0] pend_val[$];

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;
  int cyc, we_cnt, busy_cnt, first_busy, done_cyc, done_cnt;
  logic [7:0] ovl_exp [4];

  dma_mem #(.ADDR_W(6), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .modo(modo), .src(src), .dst(dst),
    .len(len), .fill_val(fill_val), .mem_rd(mem_rd), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .busy(busy), .done(done)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Memory being mastered: DMA writes win, the bench backdoor preloads while idle
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wd;
    else if (tb_we) mem[tb_addr] <= tb_wd;
  end
  assign mem_rd = mem[mem_addr];

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Per-cycle compare of DUT outputs against the expected bus trace
  always @(negedge clk) begin
    if (chk_en) begin
      exp_t e;
      cyc++;
      if (busy) begin
        busy_cnt++;
        if (first_busy < 0) first_busy = cyc;
      end
      if (mem_we) we_cnt++;
      if (done) begin
        done_cyc = cyc;
        done_cnt++;
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput($sformatf("c%0d_busy", cyc), busy, e.busy);
        checkOutput($sformatf("c%0d_done", cyc), done, e.done);
        checkOutput($sformatf("c%0d_we", cyc), mem_we, e.we);
        if (e.chk_addr) checkOutput($sformatf("c%0d_addr", cyc), mem_addr, e.addr);
        if (e.chk_wd) checkOutput($sformatf("c%0d_wd", cyc), mem_wd, e.wd);
      end else begin
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_done", done, 0);
        checkOutput("idle_we", mem_we, 0);
      end
    end
  end

  task automatic writeWord(input int a, input logic [7:0] v);
    @(negedge clk); #1;
    tb_we = 1; tb_addr = 6'(a); tb_wd = v;
    ref_mem[a] = v;
  endtask

  task automatic endWrites();
    @(negedge clk); #1;
    tb_we = 0;
  endtask

  // Start a transfer and build the expected bus trace from the transfer rules
  task automatic applyStimulus(input logic m, input logic [5:0] s, input logic [5:0] d,
                               input logic [6:0] l, input logic [7:0] f);
    logic [7:0] sim [64];
    int n, i, dd;
    bit desc;
    exp_t e;
    @(negedge clk); #1;
    modo = m; src = s; dst = d; len = l; fill_val = f; start = 1;
    n = (l > 64) ? 64 : int'(l);
    dd = (int'(d) - int'(s)) & 63;
    desc = 0;
`ifdef DMA_OVERLAP_EN
    desc = (m == 0) && (dd > 0) && (dd < n);
`endif
    sim = ref_mem;
    for (int k = 0; k < n; k++) begin
      i = desc ? (n - 1 - k) : k;
      if (m == 0) begin
        e = '{busy: 1, done: 0, we: 0, chk_addr: 1, addr: 6'((int'(s) + i) & 63), chk_wd: 0, wd: 0};
        exp_q.push_back(e);
      end
      e = '{busy: 1, done: 0, we: 1, chk_addr: 1, addr: 6'((int'(d) + i) & 63), chk_wd: 1,
            wd: (m ? f : sim[(int'(s) + i) & 63])};
      exp_q.push_back(e);
      sim[(int'(d) + i) & 63] = e.wd;
      pend_addr.push_back((int'(d) + i) & 63);
      pend_val.push_back(e.wd);
    end
    e = '{busy: 1, done: 1, we: 0, chk_addr: 0, addr: 0, chk_wd: 0, wd: 0};
    exp_q.push_back(e);
    cyc = 0; we_cnt = 0; busy_cnt = 0; first_busy = -1; done_cyc = -1; done_cnt = 0;
    @(negedge clk); #1;
    start = 0;
  endtask

  task automatic commitWrites(input int count);
    for (int k = 0; k < count && pend_addr.size() > 0; k++) begin
      ref_mem[pend_addr.pop_front()] = pend_val.pop_front();
    end
    pend_addr.delete();
    pend_val.delete();
  endtask

  task automatic waitDone();
    for (int k = 0; k < 300 && exp_q.size() > 0; k++) @(negedge clk);
    checkOutput("timeout_left", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk); #1;
    commitWrites(64);
  endtask

  task automatic checkMem(input string name);
    int bad = 0;
    for (int a = 0; a < 64; a++) if (mem[a] !== ref_mem[a]) bad++;
    checkOutput(name, bad, 0);
  endtask

  initial begin
`ifdef DMA_OVERLAP_EN
    ovl_exp[0] = 8'h01; ovl_exp[1] = 8'h02; ovl_exp[2] = 8'h03; ovl_exp[3] = 8'h04;
`else
    ovl_exp[0] = 8'h01; ovl_exp[1] = 8'h02; ovl_exp[2] = 8'h01; ovl_exp[3] = 8'h02;
`endif
    reset = 0; start = 0; modo = 0; src = 0; dst = 0; len = 0; fill_val = 0;
    tb_we = 0; tb_addr = 0; tb_wd = 0;
    #2;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_we", mem_we, 0);
    checkOutput("rst_addr", mem_addr, 0);
    checkOutput("rst_wd", mem_wd, 0);
    @(negedge clk); #1;
    reset = 1;
    chk_en = 1;
    for (int a = 0; a < 64; a++) writeWord(a, 8'h80 | 8'(a));
    endWrites();

    // Fill 10..14 with A5
    applyStimulus(1, 6'd10, 6'd10, 7'd5, 8'hA5);
    waitDone();
    checkMem("fill_mem");
    checkOutput("fill_m14", mem[14], 8'hA5);
    checkOutput("fill_m15", mem[15], 8'h8F);
    checkOutput("fill_done_cyc", done_cyc, 6);
    checkOutput("fill_we_cnt", we_cnt, 5);

    // Copy 0..3 to 20..23
    writeWord(0, 8'h01); writeWord(1, 8'h02); writeWord(2, 8'h03); writeWord(3, 8'h04);
    endWrites();
    applyStimulus(0, 6'd0, 6'd20, 7'd4, 8'h00);
    waitDone();
    checkMem("copy_mem");
    checkOutput("copy_m20", mem[20], 8'h01);
    checkOutput("copy_m23", mem[23], 8'h04);
    checkOutput("copy_done_cyc", done_cyc, 9);
    checkOutput("copy_busy_cnt", busy_cnt, 9);
    checkOutput("copy_first_busy", first_busy, 1);

    // Zero-length transfer
    applyStimulus(1, 6'd0, 6'd40, 7'd0, 8'hEE);
    waitDone();
    checkOutput("len0_done_cyc", done_cyc, 1);
    checkOutput("len0_we_cnt", we_cnt, 0);
    checkMem("len0_mem");

    // Start pulsed while busy must be ignored
    applyStimulus(0, 6'd0, 6'd48, 7'd4, 8'h00);
    @(negedge clk); #1;
    modo = 1; src = 6'd5; dst = 6'd7; len = 7'd2; fill_val = 8'hFF; start = 1;
    @(negedge clk); #1;
    start = 0;
    waitDone();
    checkMem("busy_start_mem");
    checkOutput("busy_start_done_cnt", done_cnt, 1);
    checkOutput("busy_start_m51", mem[51], 8'h04);
    checkOutput("busy_start_m7", mem[7], 8'h87);

    // Wrap and clamp: fill from 62 with len 70
    applyStimulus(1, 6'd0, 6'd62, 7'd70, 8'hC3);
    waitDone();
    checkMem("clamp_mem");
    checkOutput("clamp_done_cyc", done_cyc, 65);
    checkOutput("clamp_we_cnt", we_cnt, 64);

    // Reset in cycle 3 of an 8-word fill
    applyStimulus(1, 6'd0, 6'd30, 7'd8, 8'h5A);
    @(negedge clk);
    @(negedge clk);
    #2;
    chk_en = 0;
    reset = 0;
    #1;
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_we", mem_we, 0);
    checkOutput("mid_rst_done", done, 0);
    exp_q.delete();
    commitWrites(2);
    @(negedge clk);
    @(negedge clk); #1;
    reset = 1;
    @(negedge clk);
    checkOutput("post_rst_busy", busy, 0);
    checkOutput("post_rst_done", done, 0);
    checkOutput("post_rst_we", mem_we, 0);
    checkMem("rst_mem");
    checkOutput("rst_m31", mem[31], 8'h5A);
    checkOutput("rst_m32", mem[32], 8'hC3);
    chk_en = 1;

    // Overlapping copy 0..3 -> 2..5
    writeWord(0, 8'h01); writeWord(1, 8'h02); writeWord(2, 8'h03); writeWord(3, 8'h04);
    endWrites();
    applyStimulus(0, 6'd0, 6'd2, 7'd4, 8'h00);
    waitDone();
    checkMem("ovl_mem");
    for (int k = 0; k < 4; k++) checkOutput($sformatf("ovl_m%0d", k + 2), mem[k + 2], ovl_exp[k]);
    checkOutput("ovl_done_cyc", done_cyc, 9);

    repeat (3) @(negedge clk);
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dma_mem.md
Name: dma_mem

Overview:
- Block-transfer initiator for the 64x8 data memory; it is the master side of the memory's we/addr/wd/rd port.
- Performs block copy (memory to memory) or block fill (constant to memory) without CPU instruction-level loops.
- Sits beside the CPU datapath; a mux selects CPU or dma_mem as memory master, and `busy` drives that select.

Parameters:
- ADDR_W, 6, memory address width; address space is 2**ADDR_W words.
- DATA_W, 8, memory word width.

Ports:
- clk  in  1  system clock, all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request; sampled on rising edge, only in IDLE
- modo  in  1  0 = copy, 1 = fill; latched with start
- src  in  ADDR_W  copy source base address; latched with start
- dst  in  ADDR_W  destination base address; latched with start
- len  in  ADDR_W+1  word count, 0..64; latched with start
- fill_val  in  DATA_W  fill constant; latched with start
- mem_rd  in  DATA_W  memory read data, combinational from mem_addr
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory read/write address
- mem_wd  out  DATA_W  memory write data
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- Clock port is `clk`. Reset port is `reset`, asynchronous and active-low: `reset` = 0 forces the reset state immediately, with no clock required.
- Reset values: state = IDLE, busy = 0, done = 0, mem_we = 0, mem_addr = 0, mem_wd = 0, internal counter = 0, data register = 0.
- States are IDLE, LEER, ESCRIBIR and FIN.
- IDLE:
  - On start = 1, latch modo, src, dst, fill_val and len_eff, where len_eff = min(len, 64).
  - Clear index i.
  - If len_eff = 0, go to FIN. Otherwise go to LEER for copy or ESCRIBIR for fill.
- LEER (copy only):
  - mem_addr = src + i, mem_we = 0.
  - Capture mem_rd into the data register at the clock edge, then go to ESCRIBIR.
- ESCRIBIR:
  - mem_addr = dst + i, mem_we = 1.
  - mem_wd = data register for copy, fill_val for fill.
  - At the edge, i <= i + 1.
  - If i + 1 = len_eff, go to FIN; else go to LEER (copy) or stay in ESCRIBIR (fill).
- FIN: done = 1 for exactly one cycle, then go to IDLE.
- busy = 1 in LEER, ESCRIBIR and FIN; busy = 0 in IDLE.
- mem_we, mem_addr and mem_wd are decoded from state and registers. mem_we = 1 only in ESCRIBIR.
- Address arithmetic is modulo 2**ADDR_W. Example: dst = 62, len = 4 writes addresses 62, 63, 0, 1.
- Default transfer order is ascending.
- Latency, counting the start edge as edge 0:
  - Copy of N words: 2N cycles of transfer; done is high in cycle 2N+1.
  - Fill of N words: N cycles of transfer; done is high in cycle N+1.
  - len = 0: done is high in cycle 1 with no writes.
- start while busy is ignored. It is not queued and does not change the latched operands.
- start held high through FIN: a new transfer begins only at the first edge after returning to IDLE, so there is at least one idle cycle between transfers.
- len > 64 is clamped to 64. Each address is then written exactly once.
- Reset mid-transfer: mem_we drops immediately. Partially written data remains in memory, and no done pulse is generated.
- Without the optional feature, overlap is not handled: a copy with dst inside (src, src+len) reads already-overwritten words.

Optional Feature:
- Macro: DMA_OVERLAP_EN.
- Defined: at start, compute d = (dst - src) mod 64. If modo = copy and 0 < d < len_eff, copy in descending order: i runs from len_eff-1 down to 0, and completion is the write of i = 0. The result has memmove semantics. Latency is unchanged.
- Not defined: always ascending, and the overlap corruption described above applies.

Test Plan:
- Fill: modo=1, dst=10, len=5, fill_val=8'hA5 -> addresses 10..14 = A5, address 15 unchanged; done in cycle 6; exactly 5 cycles with mem_we = 1.
- Copy: memory[0..3] = 01,02,03,04; modo=0, src=0, dst=20, len=4 -> memory[20..23] = 01..04; done in cycle 9; busy high in cycles 1..9.
- Wrap and clamp: fill dst=62, len=70 -> all 64 words written once, in address order 62, 63, 0..61; done in cycle 65.
- len=0, and start pulsed while busy: len=0 -> done in cycle 1 with mem_we never 1. A second start during a 4-word copy is ignored: one done pulse only, and the original operands are used.
- Reset: assert reset=0 during cycle 3 of an 8-word fill -> busy, mem_we and done go to 0 without a clock edge; after release, state is IDLE; only the words already written hold fill_val.
- Overlap: memory[0..3] = 01..04; copy src=0, dst=2, len=4 -> with DMA_OVERLAP_EN, memory[2..5] = 01,02,03,04; without it, memory[2..5] = 01,02,01,02.
